// File: rtl/fu_sched_pkg.sv
// Shared types for the functional-unit scheduler: FU indices, FU mask type,
// divider state encoding and a one-hot helper.
package fu_sched_pkg;

    localparam int NUM_FU = 5;
    localparam int FU_ALU = 0;
    localparam int FU_BRU = 1;
    localparam int FU_MUL = 2;
    localparam int FU_DIV = 3;
    localparam int FU_LSU = 4;

    typedef logic [NUM_FU-1:0] fu_mask_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    function automatic logic is_onehot(input fu_mask_t m);
        return (m != '0) && ((m & (m - fu_mask_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/fu_sched_div_fsm.sv
// Divider occupancy tracker: IDLE/BUSY with a down-counter bounding the
// worst-case latency; an early div_done releases the unit.
module div_fsm
    import fu_sched_pkg::*;
#(
    parameter int divlat = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_start,
    input  logic i_done,
    output logic o_idle,
    output logic o_busy
);

    localparam int CW = (divlat > 1) ? $clog2(divlat) : 1;

    div_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_idle;
    logic            r_busy;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_idle  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_state <= DIV_BUSY;
                        r_cnt   <= CW'(divlat - 1);
                        r_idle  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                DIV_BUSY: begin
                    // A start arriving while busy is never granted upstream,
                    // so only the release conditions matter here.
                    if (i_done || r_cnt == '0) begin
                        r_state <= DIV_IDLE;
                        r_cnt   <= '0;
                        r_idle  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_cnt   <= '0;
                    r_idle  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_idle = r_idle;
    assign o_busy = r_busy;

endmodule

// File: rtl/fu_sched.sv
// In-order issue arbiter: grants a prefix of valid issue slots against the
// per-cycle capacity of ALU/BRU/MUL/DIV/LSU and tracks MUL, DIV and LSQ occupancy.
module fu_sched
    import fu_sched_pkg::*;
#(
    parameter int iwd    = 4,
    parameter int divlat = 16,
    parameter int lsqsz  = 8,
    parameter int mullat = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_redir,
    input  logic [iwd-1:0]          i_iss_valid,
    input  logic [iwd*NUM_FU-1:0]   i_iss_fu,
    input  logic                    i_div_done,
    input  logic [1:0]              i_lsu_free,
    output logic [NUM_FU-1:0]       o_fu_ready,
    output logic [iwd-1:0]          o_issue,
    output logic                    o_div_busy,
    output logic [$clog2(lsqsz):0]  o_lsu_cred
);

    localparam int CRW = $clog2(lsqsz) + 1;
    localparam int MIW = $clog2(mullat + 1);

    logic [mullat-1:0] r_mul_sr;
    logic [MIW-1:0]    r_mul_inf;
    logic [CRW-1:0]    r_lsu_cred;

    logic              w_div_idle;
    logic              w_div_busy;
    logic              w_mul_ok;
    logic [iwd-1:0]    w_issue;
    logic              w_mul_gnt;
    logic              w_div_gnt;
    logic [CRW-1:0]    w_lsu_n;
    logic              w_open;
    logic              w_bru_cap;
    logic              w_mul_cap;
    logic              w_div_cap;
    logic [CRW-1:0]    w_lsu_cap;
    fu_mask_t          w_m;
    logic              w_ok;
    logic [CRW:0]      w_cred_sum;
    logic [CRW-1:0]    w_cred_nxt;

    assign w_mul_ok = (r_mul_inf < MIW'(mullat));

    // Walk slots oldest-first, consuming capacity; the first denied valid slot
    // closes the window so younger slots cannot pass it.
    always_comb begin
        w_issue   = '0;
        w_mul_gnt = 1'b0;
        w_div_gnt = 1'b0;
        w_lsu_n   = '0;
        w_open    = !i_redir;
        w_bru_cap = 1'b1;
        w_mul_cap = w_mul_ok;
        w_div_cap = w_div_idle;
        w_lsu_cap = r_lsu_cred;
        w_m       = '0;
        w_ok      = 1'b0;
        for (int i = 0; i < iwd; i++) begin
            w_m  = i_iss_fu[i*NUM_FU +: NUM_FU];
            w_ok = is_onehot(w_m) &&
                   (w_m[FU_ALU] ||
                    (w_m[FU_BRU] && w_bru_cap) ||
                    (w_m[FU_MUL] && w_mul_cap) ||
                    (w_m[FU_DIV] && w_div_cap) ||
                    (w_m[FU_LSU] && (w_lsu_cap != '0)));
            if (i_iss_valid[i]) begin
                if (w_open && w_ok) begin
                    w_issue[i] = 1'b1;
                    if (w_m[FU_BRU]) w_bru_cap = 1'b0;
                    if (w_m[FU_MUL]) begin
                        w_mul_cap = 1'b0;
                        w_mul_gnt = 1'b1;
                    end
                    if (w_m[FU_DIV]) begin
                        w_div_cap = 1'b0;
                        w_div_gnt = 1'b1;
                    end
                    if (w_m[FU_LSU]) begin
                        w_lsu_cap = w_lsu_cap - CRW'(1);
                        w_lsu_n   = w_lsu_n + CRW'(1);
                    end
                end else begin
                    w_open = 1'b0;
                end
            end
        end
    end

    // Grants never exceed the current credit count, so the sum cannot underflow.
    always_comb begin
        w_cred_sum = (CRW+1)'(r_lsu_cred) - (CRW+1)'(w_lsu_n)
                   + (CRW+1)'(i_lsu_free[0]) + (CRW+1)'(i_lsu_free[1]);
        w_cred_nxt = (w_cred_sum > (CRW+1)'(lsqsz)) ? CRW'(lsqsz) : w_cred_sum[CRW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_sr   <= '0;
            r_mul_inf  <= '0;
            r_lsu_cred <= CRW'(lsqsz);
        end else begin
            r_lsu_cred <= w_cred_nxt;
            if (i_redir) begin
                r_mul_sr  <= '0;
                r_mul_inf <= '0;
            end else begin
                r_mul_sr  <= (r_mul_sr << 1) | mullat'(w_mul_gnt);
                r_mul_inf <= r_mul_inf + MIW'(w_mul_gnt) - MIW'(r_mul_sr[mullat-1]);
            end
        end
    end

    div_fsm #(.divlat(divlat)) u_div_fsm (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (i_redir),
        .i_start (w_div_gnt),
        .i_done  (i_div_done),
        .o_idle  (w_div_idle),
        .o_busy  (w_div_busy)
    );

    assign o_fu_ready[FU_ALU] = 1'b1;
    assign o_fu_ready[FU_BRU] = 1'b1;
    assign o_fu_ready[FU_MUL] = w_mul_ok;
    assign o_fu_ready[FU_DIV] = w_div_idle;
    assign o_fu_ready[FU_LSU] = (r_lsu_cred != '0);
    assign o_issue            = w_issue;
    assign o_div_busy         = w_div_busy;
    assign o_lsu_cred         = r_lsu_cred;

endmodule

// File: tb/tb_fu_sched.sv
// Self-checking bench for fu_sched: directed literal cases followed by random
// traffic compared every cycle against an occupancy-interval reference model.
module tb_fu_sched;

    localparam int IWD = 4, DIVLAT = 16, LSQ = 8, MULLAT = 3, NF = 5;
    localparam logic [4:0] A = 5'b00001, B = 5'b00010, M = 5'b00100,
                           D = 5'b01000, L = 5'b10000, Z = 5'b00000;

    logic              clk = 1'b0;
    logic              rst, redir, div_done;
    logic [IWD-1:0]    iss_valid;
    logic [IWD*NF-1:0] iss_fu;
    logic [1:0]        lsu_free;
    logic [NF-1:0]     fu_ready;
    logic [IWD-1:0]    issue;
    logic              div_busy;
    logic [3:0]        lsu_cred;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    fu_sched #(.iwd(IWD), .divlat(DIVLAT), .lsqsz(LSQ), .mullat(MULLAT)) dut (
        .clk(clk), .rst(rst), .i_redir(redir), .i_iss_valid(iss_valid),
        .i_iss_fu(iss_fu), .i_div_done(div_done), .i_lsu_free(lsu_free),
        .o_fu_ready(fu_ready), .o_issue(issue), .o_div_busy(div_busy),
        .o_lsu_cred(lsu_cred)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: divider busy over a cycle interval, MUL grants kept as
    // a list of grant cycles, LSQ credits as a plain integer.
    int  m_cred, m_div_until, cyc = 0;
    int  mq[$];
    bit  m_on = 0;

    function automatic int mul_inf(input int c);
        int n = 0;
        foreach (mq[k]) if (mq[k] < c && c <= mq[k] + MULLAT) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        bit dbusy, bru, mulc, divc, open, dgnt, ok;
        int mi, lsu_left, nl;
        logic [4:0] m;
        logic [IWD-1:0] ei;
        if (rst) begin
            m_cred = LSQ; m_div_until = -1; mq.delete(); m_on = 1;
        end else if (m_on) begin
            dbusy = (cyc <= m_div_until);
            mi = mul_inf(cyc);
            lsu_left = m_cred; nl = 0;
            bru = 1; mulc = (mi < MULLAT); divc = !dbusy; open = !redir; dgnt = 0;
            ei = '0;
            for (int i = 0; i < IWD; i++) begin
                m = iss_fu[i*NF +: NF];
                ok = ($countones(m) == 1) && (m[0] || (m[1] && bru) || (m[2] && mulc) ||
                                              (m[3] && divc) || (m[4] && lsu_left > 0));
                if (iss_valid[i]) begin
                    if (open && ok) begin
                        ei[i] = 1'b1;
                        if (m[1]) bru = 0;
                        if (m[2]) begin mulc = 0; mq.push_back(cyc); end
                        if (m[3]) begin divc = 0; dgnt = 1; end
                        if (m[4]) begin lsu_left--; nl++; end
                    end else open = 0;
                end
            end
            chk("issue", issue, ei);
            chk("fu_ready", fu_ready, {m_cred > 0, !dbusy, mi < MULLAT, 1'b1, 1'b1});
            chk("div_busy", div_busy, dbusy);
            chk("lsu_cred", lsu_cred, m_cred);
            if (redir) begin
                mq.delete();
                if (dbusy) m_div_until = cyc;
            end else if (dgnt) m_div_until = cyc + DIVLAT;
            else if (dbusy && div_done) m_div_until = cyc;
            m_cred = m_cred - nl + $countones(lsu_free);
            if (m_cred > LSQ) m_cred = LSQ;
            while (mq.size() > 0 && mq[0] + MULLAT < cyc) void'(mq.pop_front());
        end
        cyc++;
    end

    task automatic drive(input logic [3:0] v, input logic [19:0] fu,
                         input logic dd = 1'b0, input logic [1:0] fr = 2'b00,
                         input logic rd = 1'b0);
        @(posedge clk); #1;
        iss_valid = v; iss_fu = fu; div_done = dd; lsu_free = fr; redir = rd;
        @(negedge clk);
    endtask

    initial begin
        int nb;
        logic [4:0] sm;
        int r;
        rst = 1; redir = 0; div_done = 0; iss_valid = '0; iss_fu = '0; lsu_free = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ready", fu_ready, 5'b11111);
        chk("rst_issue", issue, 0);
        chk("rst_busy", div_busy, 0);
        chk("rst_cred", lsu_cred, 8);

        drive(4'b1111, {A, A, A, A});
        chk("alu4_issue", issue, 4'b1111);
        chk("alu4_ready", fu_ready, 5'b11111);
        chk("alu4_cred", lsu_cred, 8);

        // DIV, DIV, ALU, ALU: second DIV blocks, then early div_done
        drive(4'b1111, {A, A, D, D});
        chk("div2_issue", issue, 4'b0001);
        drive(4'b0000, '0);
        chk("div_busy_next", div_busy, 1);
        chk("div_ready_low", fu_ready[3], 0);
        drive(4'b0000, '0);
        drive(4'b0000, '0);
        drive(4'b0000, '0, 1'b1);
        drive(4'b0000, '0);
        chk("div_done_ready", fu_ready[3], 1);

        // Divider with no done: busy for exactly divlat cycles
        drive(4'b0001, {Z, Z, Z, D});
        nb = 0;
        repeat (20) begin
            drive(4'b0000, '0);
            if (div_busy) nb++;
        end
        chk("div_busy_len", nb, 16);

        // Drain credits to 1, then LSU, LSU, ALU
        drive(4'b1111, {L, L, L, L});
        chk("lsu4_issue", issue, 4'b1111);
        drive(4'b0111, {Z, L, L, L});
        chk("lsu3_issue", issue, 4'b0111);
        drive(4'b0111, {Z, A, L, L});
        chk("cred_one", lsu_cred, 1);
        chk("lsu_lla_issue", issue, 4'b0001);
        drive(4'b0000, '0);
        chk("cred_zero", lsu_cred, 0);
        chk("lsu_ready_low", fu_ready[4], 0);
        drive(4'b0000, '0, 1'b0, 2'b01);
        drive(4'b0111, {Z, A, L, L}, 1'b0, 2'b11);
        chk("lsu_net_issue", issue, 4'b0001);
        drive(4'b0000, '0);
        chk("cred_net", lsu_cred, 2);

        drive(4'b0111, {Z, A, B, B});
        chk("bru2_issue", issue, 4'b0001);
        drive(4'b0111, {Z, A, Z, A});
        chk("zero_mask_issue", issue, 4'b0001);
        drive(4'b0011, {Z, Z, A, 5'b00011});
        chk("multihot_issue", issue, 4'b0000);
        drive(4'b1111, {A, A, B, A});
        chk("mixed_issue", issue, 4'b1111);

        // Three back-to-back MULs saturate the pipeline for one cycle
        drive(4'b0001, {Z, Z, Z, M});
        drive(4'b0011, {Z, Z, M, M});
        chk("mul_one_per_cycle", issue, 4'b0001);
        drive(4'b0001, {Z, Z, Z, M});
        drive(4'b0000, '0);
        chk("mul_sat", fu_ready[2], 0);
        drive(4'b0000, '0);
        chk("mul_free", fu_ready[2], 1);

        // Redirect while divider busy and two MULs in flight
        drive(4'b0001, {Z, Z, Z, D});
        drive(4'b0001, {Z, Z, Z, M});
        drive(4'b0001, {Z, Z, Z, M});
        drive(4'b1111, {A, A, A, A}, 1'b0, 2'b00, 1'b1);
        chk("redir_issue", issue, 0);
        chk("redir_busy", div_busy, 1);
        drive(4'b0000, '0);
        chk("redir_ready", fu_ready, 5'b11111);
        chk("redir_busy_clr", div_busy, 0);
        chk("redir_cred", lsu_cred, 2);

        // Random traffic, including occasional mid-operation reset
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            redir     = ($urandom_range(0, 19) == 0);
            div_done  = ($urandom_range(0, 5) == 0);
            lsu_free  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            iss_valid = 4'($urandom);
            for (int s = 0; s < IWD; s++) begin
                r = $urandom_range(0, 11);
                if (r < 5)       sm = 5'(1 << r);
                else if (r == 5) sm = 5'b0;
                else if (r == 6) sm = 5'($urandom);
                else             sm = 5'(1 << (r - 7));
                iss_fu[s*NF +: NF] = sm;
            end
            @(negedge clk);
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fu_sched.md
FU_SCHED -- requirements
Module: fu_sched

Interface
REQ-001 Parameter iwd, default 4: issue width, number of issue slots arbitrated per cycle.
REQ-002 Parameter divlat, default 16: maximum divider occupancy in cycles, counted from grant.
REQ-003 Parameter lsqsz, default 8: load/store queue entry credits.
REQ-004 Parameter mullat, default 3: multiplier pipeline depth.
REQ-005 clk  input  1: clock.
REQ-006 rst  input  1: reset, synchronous, active-high.
REQ-007 redir  input  1: pipeline redirect, i.e. flush.
REQ-008 iss_valid  input  iwd: issue-slot valid, in program order, slot 0 oldest.
REQ-009 iss_fu  input  iwd x 5: one-hot FU mask per slot; bit0 ALU, bit1 BRU, bit2 MUL, bit3 DIV, bit4 LSU.
REQ-010 div_done  input  1: divider result written back.
REQ-011 lsu_free  input  2: LSQ entries released this cycle, one per bit.
REQ-012 fu_ready  output  5: per-FU availability, driven to the issue queue.
REQ-013 issue  output  iwd: per-slot grant, returned to the issue queue.
REQ-014 div_busy  output  1: divider occupied.
REQ-015 lsu_cred  output  clog2(lsqsz)+1: free LSQ credits.

Function
REQ-016 fu_ready[0] SHALL be constant 1, because the ALU is fully pipelined.
REQ-017 fu_ready[1] SHALL be 1, and at most one BRU slot SHALL be granted per cycle.
REQ-018 fu_ready[2] SHALL be 1 iff mul_inflight < mullat; mul_inflight increments on a MUL grant and decrements mullat cycles later via a mullat-bit shift register, at most one MUL grant per cycle.
REQ-019 The divider FSM SHALL have states IDLE and BUSY, with fu_ready[3] = (state == IDLE) and div_busy = (state == BUSY).
REQ-020 IDLE->BUSY SHALL occur on a DIV grant and load the counter with divlat-1.
REQ-021 BUSY->IDLE SHALL occur on div_done or when the counter reaches 0, whichever comes first; the counter decrements by 1 per BUSY cycle.
REQ-022 fu_ready[4] SHALL be 1 iff lsu_cred > 0.
REQ-023 Each cycle, lsu_cred SHALL update as lsu_cred - (LSU grants) + popcount(lsu_free), saturating at lsqsz.
REQ-024 Grants SHALL be combinational and in order: slot i is granted iff iss_valid[i], all earlier valid slots are granted, and its FU retains capacity after the earlier grants of the same cycle.
REQ-025 Same-cycle capacity SHALL be: DIV 1 if IDLE else 0; MUL 1 if not saturated; BRU 1; LSU lsu_cred; ALU unlimited.
REQ-026 The first denied slot SHALL block all younger slots, so issue is always a prefix mask.
REQ-027 A slot whose mask is all-zero or multi-hot SHALL be denied.
REQ-028 On redir: divider to IDLE, counter 0, mul shift register and mul_inflight cleared, issue forced to 0 that cycle; lsu_cred is unaffected.
REQ-029 Simultaneous div_done and a DIV grant in the same cycle SHALL keep the FSM in BUSY, because the grant is blocked while BUSY, so the grant is applied next cycle.
REQ-030 LSU grants and lsu_free in the same cycle SHALL be netted; lsu_cred SHALL never underflow.

Reset
REQ-031 On rst: divider IDLE, counter 0, mul_inflight 0, shift register 0, lsu_cred = lsqsz.
REQ-032 After reset: fu_ready = 5'b11111, issue = 0, div_busy = 0.
REQ-033 rst SHALL take priority over redir and over all updates, including reset asserted mid-division.

Structure
REQ-034 The FU index constants (FU_ALU=0, FU_BRU=1, FU_MUL=2, FU_DIV=3, FU_LSU=4) and the fu_mask_t typedef SHALL live in the shared types package.
REQ-035 One sub-module, div_fsm, SHALL contain the divider IDLE/BUSY state and its counter; everything else stays in fu_sched.

Verification
REQ-036 Reset, then iss_valid=4'b1111 with all ALU -> issue=4'b1111, fu_ready=5'b11111, lsu_cred=8.
REQ-037 Slots DIV, DIV, ALU, ALU -> issue=4'b0001; next cycle div_busy=1 and fu_ready[3]=0; div_done at cycle 5 -> fu_ready[3]=1 the cycle after.
REQ-038 DIV granted with no div_done -> div_busy high for exactly 16 cycles.
REQ-039 lsu_cred=1, slots LSU, LSU, ALU -> issue=4'b0001 and lsu_cred becomes 0; same stimulus with lsu_free=2'b11 -> lsu_cred becomes 2.
REQ-040 A MUL issued on each of 3 consecutive cycles -> fu_ready[2]=0 on cycle 4 and 1 on cycle 5.
REQ-041 redir while the divider is BUSY and 2 MULs are in flight -> next cycle fu_ready=5'b11111, issue=0 during the redir cycle, lsu_cred unchanged.
